led_fader: RTL and testbench

- Downstream stage of the 1 Hz alternating LED pattern generator on the gm-study-e1 board.
- Consumes its 10-bit on/off pattern and drives the 10 physical LEDs.
- Each hard on/off edge becomes a linear brightness ramp using per-LED PWM. All LEDs share one PWM counter and one ramp prescaler.
- Same 10 MHz clock domain as the pattern generator; the pattern bus needs no CDC.

---
 rtl/led_pkg.sv | 14 +
 rtl/led_pwm_channel.sv | 70 +++++++
 rtl/led_fader.sv | 65 ++++++
 tb/tb_led_fader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and types for the LED fader
//
// Purpose: board-level defaults shared by led_fader and led_pwm_channel.
// Ports:   none (package).
package led_pkg;

  localparam int NLED_DEFAULT     = 10;
  localparam int PWM_BITS_DEFAULT = 4;
  localparam int CLK_HZ           = 10_000_000;

  // Brightness level at the default resolution.
  typedef logic [PWM_BITS_DEFAULT-1:0] level_t;

endpackage

// File: rtl/led_pwm_channel.sv
// rtl/led_pwm_channel.sv - one LED: brightness ramp, duty latch, PWM output flop
//
// Purpose: tracks the brightness level toward full-on or off, latches it as the
//          PWM duty at each period boundary and drives a registered PWM bit.
// Ports:
//   i_clk        system clock
//   i_rst        asynchronous active-low reset
//   i_target_on  1 = target full brightness, 0 = target dark
//   i_fade_en    1 = ramp one step per tick, 0 = snap to target
//   i_ramp_tick  shared ramp prescaler tick
//   i_pwm_cnt    shared PWM counter
//   o_led        registered PWM drive
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_target_on,
  input  logic                i_fade_en,
  input  logic                i_ramp_tick,
  input  logic [PWM_BITS-1:0] i_pwm_cnt,
  output logic                o_led
);

  localparam logic [PWM_BITS-1:0] MAX = '1;

  logic [PWM_BITS-1:0] r_level;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_led;

  logic [PWM_BITS-1:0] w_target;
  logic [PWM_BITS-1:0] w_level_nxt;

  // Target is always an endpoint (0 or MAX), so a single step toward it can
  // never leave 0..MAX or wrap.
  always_comb begin
    w_target    = i_target_on ? MAX : '0;
    w_level_nxt = r_level;
    if (!i_fade_en) begin
      w_level_nxt = w_target;
    end else if (i_ramp_tick) begin
      if (r_level < w_target) begin
        w_level_nxt = r_level + 1'b1;
      end else if (r_level > w_target) begin
        w_level_nxt = r_level - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_level <= '0;
      r_duty  <= '0;
      r_led   <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      // Duty only moves on the last count of a period: no runt pulses.
      if (i_pwm_cnt == MAX) begin
        r_duty <= r_level;
      end
      // MAX is treated as fully on rather than MAX/(MAX+1).
      r_led <= (r_duty == MAX) | (r_duty > i_pwm_cnt);
    end
  end

  assign o_led = r_led;

endmodule

// File: rtl/led_fader.sv
// rtl/led_fader.sv - turns a hard on/off LED pattern into PWM brightness fades
//
// Purpose: registers the upstream pattern, runs the shared PWM counter and
//          ramp prescaler, and instantiates one PWM channel per LED.
// Ports:
//   clk      10 MHz system clock
//   rst      asynchronous active-low reset
//   led_in   on/off pattern, bit=1 targets full brightness
//   fade_en  1 = linear ramp toward target, 0 = snap
//   led_out  registered PWM drive to the LED pins
module led_fader
  import led_pkg::*;
#(
  parameter int NLED     = NLED_DEFAULT,
  parameter int PWM_BITS = PWM_BITS_DEFAULT,
  // 15 steps at CLK_HZ/320 cycles each gives a ~47 ms full fade.
  parameter int RAMP_DIV = CLK_HZ / 320
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NLED-1:0] led_in,
  input  logic            fade_en,
  output logic [NLED-1:0] led_out
);

  // RAMP_DIV=1 still needs a 1-bit counter so the compare stays legal.
  localparam int             RW        = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RW-1:0]  RAMP_LAST = RW'(RAMP_DIV - 1);

  logic [NLED-1:0]     r_in_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [RW-1:0]       r_ramp_cnt;
  logic                w_ramp_tick;

  assign w_ramp_tick = (r_ramp_cnt == RAMP_LAST);

  // Both counters free-run; input changes never restart them, so every
  // channel ramps on the same ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_q     <= '0;
      r_pwm_cnt  <= '0;
      r_ramp_cnt <= '0;
    end else begin
      r_in_q     <= led_in;
      r_pwm_cnt  <= r_pwm_cnt + 1'b1;
      r_ramp_cnt <= w_ramp_tick ? '0 : r_ramp_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NLED; gi++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_target_on(r_in_q[gi]),
      .i_fade_en  (fade_en),
      .i_ramp_tick(w_ramp_tick),
      .i_pwm_cnt  (r_pwm_cnt),
      .o_led      (led_out[gi])
    );
  end

endmodule

// File: tb/tb_led_fader.sv
// tb/tb_led_fader.sv - self-checking bench for led_fader (RAMP_DIV 4 and 1)
module tb_led_fader;
  import led_pkg::*;

  localparam int N    = NLED_DEFAULT;
  localparam int PB   = PWM_BITS_DEFAULT;
  localparam int MAXL = (1 << PB) - 1;
  localparam int PER  = 1 << PB;

  logic         clk     = 1'b0;
  logic         rst     = 1'b0;
  logic         fade_en = 1'b0;
  logic [N-1:0] led_in  = '0;
  logic [N-1:0] led_out_a;
  logic [N-1:0] led_out_b;
  logic [N-1:0] all_on  = '1;

  always #5 clk = ~clk;

  led_fader #(.NLED(N), .PWM_BITS(PB), .RAMP_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .led_in(led_in), .fade_en(fade_en), .led_out(led_out_a)
  );
  led_fader #(.NLED(N), .PWM_BITS(PB), .RAMP_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .led_in(led_in), .fade_en(fade_en), .led_out(led_out_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Reference model, one set of state per DUT (0: RAMP_DIV=4, 1: RAMP_DIV=1).
  // m_k counts edges since reset release; the PWM phase and ramp ticks are
  // derived from it arithmetically.
  int           m_k   [2];
  logic [N-1:0] m_inq [2];
  logic [N-1:0] m_out [2];
  int           m_lvl [2][N];
  int           m_duty[2][N];

  // Per-period high counts on dut_a, checked against the model's duty.
  int  hc    [N];
  int  hc_exp[N];
  bit  hc_on;
  int  q0[$];

  function automatic void model_clear();
    for (int d = 0; d < 2; d++) begin
      m_k[d]   = 0;
      m_inq[d] = '0;
      m_out[d] = '0;
      for (int i = 0; i < N; i++) begin
        m_lvl[d][i]  = 0;
        m_duty[d][i] = 0;
      end
    end
    hc_on = 1'b0;
  endfunction

  function automatic void model_edge(int d);
    int           rdiv;
    int           pwm;
    bit           tick;
    int           tgt;
    logic [N-1:0] o;
    rdiv = (d == 0) ? 4 : 1;
    pwm  = m_k[d] % PER;
    tick = ((m_k[d] % rdiv) == rdiv - 1);
    o    = '0;
    for (int i = 0; i < N; i++) begin
      if (m_duty[d][i] == MAXL || m_duty[d][i] > pwm) o[i] = 1'b1;
      if (pwm == MAXL) m_duty[d][i] = m_lvl[d][i];
      tgt = m_inq[d][i] ? MAXL : 0;
      if (!fade_en) m_lvl[d][i] = tgt;
      else if (tick && m_lvl[d][i] < tgt) m_lvl[d][i] = m_lvl[d][i] + 1;
      else if (tick && m_lvl[d][i] > tgt) m_lvl[d][i] = m_lvl[d][i] - 1;
    end
    m_out[d] = o;
    m_inq[d] = led_in;
    m_k[d]   = m_k[d] + 1;
  endfunction

  // One clock: advance model on the rising edge, compare on the falling edge.
  task automatic step();
    int p;
    @(posedge clk);
    if (rst) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    check("out_div4", 32'(led_out_a), 32'(m_out[0]));
    check("out_div1", 32'(led_out_b), 32'(m_out[1]));
    if (rst && m_k[0] > 0) begin
      p = (m_k[0] - 1) % PER;
      if (p == 0) begin
        hc_on = 1'b1;
        for (int i = 0; i < N; i++) begin
          hc[i]     = 0;
          hc_exp[i] = (m_duty[0][i] == MAXL) ? PER : m_duty[0][i];
        end
      end
      if (hc_on) begin
        for (int i = 0; i < N; i++) hc[i] = hc[i] + int'(led_out_a[i]);
        if (p == PER - 1) begin
          for (int i = 0; i < N; i++) check($sformatf("period_high_led%0d", i), hc[i], hc_exp[i]);
          q0.push_back(hc[0]);
        end
      end
    end
  endtask

  // Called at a falling edge; holds reset low across one rising edge.
  task automatic pulse_reset();
    rst = 1'b0;
    model_clear();
    #1;
    check("async_rst_out_a", 32'(led_out_a), 0);
    check("async_rst_out_b", 32'(led_out_b), 0);
    check("async_rst_lvl5", 32'(dut_a.g_ch[5].u_ch.r_level), 0);
    step();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int           c;
    int           bad;
    int           viol;
    int           n15;
    int           mid;
    int           lv;
    int           prev;
    int           jumps;
    int           peak;
    int           r;
    logic [N-1:0] pat;

    model_clear();

    // Reset held with all targets on: dark throughout.
    led_in  = all_on;
    fade_en = 1'b0;
    repeat (6) begin
      step();
      check("rst_hold_dark", 32'(led_out_a), 0);
    end
    rst = 1'b1;
    c = 0;
    while (led_out_a !== all_on && c < 20) begin
      step();
      c++;
    end
    check("rst_release_bright", 32'(led_out_a), 32'(all_on));
    bad = 0;
    repeat (PER) begin
      step();
      if (led_out_a !== all_on) bad++;
    end
    check("rst_release_const", bad, 0);

    // Snap mode: pattern and its complement.
    for (int s = 0; s < 2; s++) begin
      pat    = (s == 0) ? N'(10'b0101010101) : N'(10'b1010101010);
      led_in = pat;
      repeat (19) step();
      bad = 0;
      repeat (PER) begin
        step();
        if (led_out_a !== pat) bad++;
      end
      check($sformatf("snap_pattern_%0d", s), bad, 0);
    end

    // Fade up LED0 from dark.
    led_in = '0;
    repeat (20) step();
    fade_en = 1'b1;
    led_in  = N'(1);
    q0.delete();
    c = 0;
    while (!(q0.size() > 0 && q0[q0.size()-1] == PER) && c < 130) begin
      step();
      c++;
    end
    lv = (q0.size() > 0) ? q0[q0.size()-1] : -1;
    check("fade_up_full", lv, PER);
    check("fade_up_in_time", 32'(c < 120), 1);
    viol = 0;
    n15  = 0;
    mid  = 0;
    for (int j = 0; j < q0.size(); j++) begin
      if (j > 0 && q0[j] < q0[j-1]) viol++;
      if (q0[j] == MAXL) n15++;
      if (q0[j] > 0 && q0[j] < MAXL) mid++;
    end
    check("fade_up_monotonic", viol, 0);
    check("fade_up_no_15_of_16", n15, 0);
    check("fade_up_intermediate", 32'(mid >= 3), 1);

    // Reversal on LED3 at level 8; LED0 fades down simultaneously.
    led_in = N'(1 << 3);
    c = 0;
    while (m_lvl[0][3] != 8 && c < 100) begin
      step();
      check("rev_lvl3_up", 32'(dut_a.g_ch[3].u_ch.r_level), m_lvl[0][3]);
      c++;
    end
    check("rev_reached8", 32'(dut_a.g_ch[3].u_ch.r_level), 8);
    led_in = '0;
    prev  = 8;
    peak  = 8;
    jumps = 0;
    lv    = 8;
    repeat (60) begin
      step();
      lv = int'(dut_a.g_ch[3].u_ch.r_level);
      if (lv - prev > 1 || prev - lv > 1) jumps++;
      if (lv > peak) peak = lv;
      prev = lv;
    end
    check("rev_no_jump", jumps, 0);
    check("rev_peak_le9", 32'(peak <= 9), 1);
    check("rev_end_dark", lv, 0);

    // Reset in the middle of an LED5 fade.
    led_in = N'(1 << 5);
    c = 0;
    while (m_lvl[0][5] != 10 && c < 100) begin
      step();
      c++;
    end
    check("rst_mid_lvl5_is10", 32'(dut_a.g_ch[5].u_ch.r_level), 10);
    pulse_reset();
    repeat (8) begin
      step();
      check("rst_restart_lvl5", 32'(dut_a.g_ch[5].u_ch.r_level), m_lvl[0][5]);
    end
    check("rst_restart_low", 32'(dut_a.g_ch[5].u_ch.r_level <= 2), 1);

    // RAMP_DIV=1: one step per cycle on every LED.
    fade_en = 1'b0;
    led_in  = '0;
    repeat (20) step();
    fade_en = 1'b1;
    led_in  = all_on;
    c = 0;
    while (dut_b.g_ch[0].u_ch.r_level != 4'(MAXL) && c < 30) begin
      step();
      c++;
      check("div1_lvl0", 32'(dut_b.g_ch[0].u_ch.r_level), m_lvl[1][0]);
    end
    check("div1_cycles_to_max", c, 16);
    repeat (20) step();
    bad = 0;
    repeat (3 * PER) begin
      step();
      if (led_out_b !== all_on) bad++;
    end
    check("div1_const_high", bad, 0);

    // Randomized traffic against the model.
    for (int t = 0; t < 1500; t++) begin
      r = int'($urandom_range(0, 199));
      if (r < 10) led_in = N'($urandom);
      else if (r < 14) fade_en = ~fade_en;
      if (r == 199) pulse_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
